miriscv_alu_issue: RTL and testbench
====================================

// Module: miriscv_alu_issue
// PURPOSE
//   Operand-issue stage directly upstream of miriscv_alu. Holds the 32x32 integer register file.
//   Accepts decoded ops over a valid/ready handshake and drives the ALU operator/operands from a registered issue slot.
//   Captures the ALU result/compare flag in a result slot and writes the result back to the register file.
//   Throughput 1 op/cycle; in-order; two register stages (ISSUE, RESULT).
// PARAMETERS
//   XLEN   32  datapath width
//   RA_W   5   register index width (2**RA_W registers, x0 hardwired to 0)
//   OP_W   5   operator width, same encoding as miriscv_alu (ADD=1..NE=14)
// PORTS
//   clk_i            in   1     clock, all state on rising edge
//   rst_i            in   1     synchronous reset, active-high
//   req_valid_i      in   1     request valid
//   req_ready_o      out  1     request accepted when valid&ready
//   req_op_i         in   OP_W  ALU operator
//   req_rs1_i        in   RA_W  operand A register
//   req_rs2_i        in   RA_W  operand B register (ignored if req_use_imm_i)
//   req_rd_i         in   RA_W  destination register
//   req_imm_i        in   XLEN  immediate
//   req_use_imm_i    in   1     1: operand B = req_imm_i
//   alu_operator_o   out  OP_W  to miriscv_alu operator_i
//   alu_operand_a_o  out  XLEN  to operand_a_i
//   alu_operand_b_o  out  XLEN  to operand_b_i
//   alu_result_i     in   XLEN  from result_o
//   alu_cmp_i        in   1     from comparision_result_o
//   res_valid_o      out  1     result slot valid
//   res_ready_i      in   1     consumer takes result when valid&ready
//   res_data_o       out  XLEN  captured ALU result
//   res_cmp_o        out  1     captured compare flag
//   res_rd_o         out  RA_W  destination of captured op
// BEHAVIOUR
//   - Clock/reset: one clock; reset is synchronous, active-high on rst_i. Reset clears ISSUE/RESULT valids, all regs x1..x31 to 0,
//     alu_*_o, res_data_o, res_cmp_o, res_rd_o to 0; res_valid_o=0; req_ready_o=1 the cycle after reset.
//     Reset mid-operation drops in-flight ops with no writeback.
//   - res_move = !res_valid | res_ready_i; iss_move = iss_valid & res_move; req_ready_o = !iss_valid | res_move (& !hazard, see CONFIG).
//   - Accept (cycle N): regs read combinationally; op/operands/rd latched into ISSUE; alu_*_o valid in N+1; res_valid_o=1 from N+2.
//   - ISSUE->RESULT on iss_move: res_data_o<=alu_result_i, res_cmp_o<=alu_cmp_i, res_rd_o<=iss_rd; same edge writes
//     regfile[iss_rd]<=alu_result_i iff op in 1..8 and iss_rd!=0. Ops 9..14 (compares) and ops 0/15+ never write.
//   - RESULT clears when res_ready_i & !iss_move; stays full when refilled same cycle (simultaneous drain+fill allowed).
//   - ISSUE holds contents and alu_*_o stable while stalled (iss_valid & !res_move).
//   - x0 reads 0 always; writes to x0 ignored. No other writes exist; RESULT-slot data is already in regfile.
//   - Idle ISSUE keeps last alu_*_o values (no X).
//   - req_ready_o may depend on request payload (hazard term); producer must hold payload while valid & !ready.
// CONFIGURATION
//   MIRISCV_ISSUE_BYPASS_EN defined: when accepting, any rs (rs1; rs2 if !use_imm) equal to a writing, valid ISSUE rd != 0
//     takes alu_result_i instead of regfile; no hazard stall (hazard=0).
//   Undefined: no forwarding; hazard = same match condition; req_ready_o forced 0 while hazard; dependent op waits until
//     producer leaves ISSUE (>=1 bubble), then reads written value from regfile.
// TESTING
//   1 Reset; ADD x1=x0+imm5 at cycle N -> res_valid_o at N+2, res_data_o=5, res_rd_o=1.
//     Then ADD x2=x1+imm7 back-to-back (BYPASS_EN) -> res_data_o=12, req_ready_o never drops.
//   2 res_ready_i=0, issue 3 ops -> third sees req_ready_o=0, alu_*_o stable.
//     Release -> results 5,12,... in order, none lost/duplicated.
//   3 ADD x0=x0+imm9, then ADD x3=x0+imm0 -> res_data_o=0, res_rd_o=3.
//   4 Load x1=-321, x2=100 via ADD imm; LTS rs1=1 rs2=2 rd=4 -> res_cmp_o=1.
//     Then ADD x5=x4+imm0 -> 0 (x4 unwritten).
//   5 Both slots full, rst_i=1 one cycle -> next cycle res_valid_o=0, req_ready_o=1.
//     ADD x6=x1+imm0 -> 0.
//   6 BYPASS_EN undefined, repeat dependent pair of 1 -> req_ready_o low exactly 1 cycle, result 12.

Source files
------------

// File: rtl/miriscv_alu_issue.sv
// Operand-issue stage in front of miriscv_alu: register file, ISSUE slot driving the ALU, RESULT slot with writeback.
// Define MIRISCV_ISSUE_BYPASS_EN to forward the ISSUE-slot result instead of stalling dependent requests.
module miriscv_alu_issue #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [OP_W-1:0] req_op_i,
  input  logic [RA_W-1:0] req_rs1_i,
  input  logic [RA_W-1:0] req_rs2_i,
  input  logic [RA_W-1:0] req_rd_i,
  input  logic [XLEN-1:0] req_imm_i,
  input  logic            req_use_imm_i,
  output logic [OP_W-1:0] alu_operator_o,
  output logic [XLEN-1:0] alu_operand_a_o,
  output logic [XLEN-1:0] alu_operand_b_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_cmp_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o,
  output logic            res_cmp_o,
  output logic [RA_W-1:0] res_rd_o
);

  localparam int NREG = 2 ** RA_W;

  logic [XLEN-1:0] regs_r [NREG];
  logic            iss_valid_r;
  logic            iss_wr_r;
  logic [RA_W-1:0] iss_rd_r;
  logic            res_valid_r;

  logic            res_move_s;
  logic            iss_move_s;
  logic            iss_fwd_s;
  logic            rs1_hit_s;
  logic            rs2_hit_s;
  logic            hazard_s;
  logic            req_ready_s;
  logic            accept_s;
  logic            wb_en_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;

  // Only the arithmetic/logic operators produce a register writeback; compares and unused codes do not.
  function automatic logic is_write_op(input logic [OP_W-1:0] op);
    return (op >= OP_W'(1)) && (op <= OP_W'(8));
  endfunction

  // Handshake, dependency detection against the ISSUE slot and operand selection for the request.
  always_comb begin
    res_move_s = !res_valid_r || res_ready_i;
    iss_move_s = iss_valid_r && res_move_s;
    iss_fwd_s  = iss_valid_r && iss_wr_r && (iss_rd_r != {RA_W{1'b0}});
    rs1_hit_s  = iss_fwd_s && (req_rs1_i == iss_rd_r);
    rs2_hit_s  = iss_fwd_s && !req_use_imm_i && (req_rs2_i == iss_rd_r);
    if (req_rs1_i == {RA_W{1'b0}}) begin
      rs1_val_s = {XLEN{1'b0}};
    end else begin
      rs1_val_s = regs_r[req_rs1_i];
    end
    if (req_rs2_i == {RA_W{1'b0}}) begin
      rs2_val_s = {XLEN{1'b0}};
    end else begin
      rs2_val_s = regs_r[req_rs2_i];
    end
`ifdef MIRISCV_ISSUE_BYPASS_EN
    hazard_s = 1'b0;
    if (rs1_hit_s) begin
      opa_s = alu_result_i;
    end else begin
      opa_s = rs1_val_s;
    end
    if (req_use_imm_i) begin
      opb_s = req_imm_i;
    end else if (rs2_hit_s) begin
      opb_s = alu_result_i;
    end else begin
      opb_s = rs2_val_s;
    end
`else
    // Without forwarding the consumer waits until the producer has written the register file.
    hazard_s = rs1_hit_s || rs2_hit_s;
    opa_s    = rs1_val_s;
    if (req_use_imm_i) begin
      opb_s = req_imm_i;
    end else begin
      opb_s = rs2_val_s;
    end
`endif
    req_ready_s = (!iss_valid_r || res_move_s) && !hazard_s;
    accept_s    = req_valid_i && req_ready_s;
    wb_en_s     = iss_move_s && iss_wr_r && (iss_rd_r != {RA_W{1'b0}});
  end

  assign req_ready_o = req_ready_s;
  assign res_valid_o = res_valid_r;

  // ISSUE slot: latches the accepted op; contents and ALU drive hold while stalled or idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_valid_r     <= 1'b0;
      iss_wr_r        <= 1'b0;
      iss_rd_r        <= {RA_W{1'b0}};
      alu_operator_o  <= {OP_W{1'b0}};
      alu_operand_a_o <= {XLEN{1'b0}};
      alu_operand_b_o <= {XLEN{1'b0}};
    end else if (accept_s) begin
      iss_valid_r     <= 1'b1;
      iss_wr_r        <= is_write_op(req_op_i);
      iss_rd_r        <= req_rd_i;
      alu_operator_o  <= req_op_i;
      alu_operand_a_o <= opa_s;
      alu_operand_b_o <= opb_s;
    end else if (iss_move_s) begin
      iss_valid_r <= 1'b0;
    end
  end

  // RESULT slot: captures the ALU output when ISSUE advances; a simultaneous drain and refill stays full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_r <= 1'b0;
      res_data_o  <= {XLEN{1'b0}};
      res_cmp_o   <= 1'b0;
      res_rd_o    <= {RA_W{1'b0}};
    end else if (iss_move_s) begin
      res_valid_r <= 1'b1;
      res_data_o  <= alu_result_i;
      res_cmp_o   <= alu_cmp_i;
      res_rd_o    <= iss_rd_r;
    end else if (res_ready_i) begin
      res_valid_r <= 1'b0;
    end
  end

  // Register file: written on the same edge the op enters RESULT; entry 0 is never written.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wb_en_s) begin
      regs_r[iss_rd_r] <= alu_result_i;
    end
  end

endmodule

// File: tb/tb_miriscv_alu_issue.sv
// Bench for miriscv_alu_issue: directed scenarios plus randomized traffic, checked against an
// architectural register-file model and an in-order queue of expected results.
module tb_miriscv_alu_issue;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_LTS = 5'd9;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_op_i;
  logic [4:0]  req_rs1_i;
  logic [4:0]  req_rs2_i;
  logic [4:0]  req_rd_i;
  logic [31:0] req_imm_i;
  logic        req_use_imm_i;
  logic [4:0]  alu_operator_o;
  logic [31:0] alu_operand_a_o;
  logic [31:0] alu_operand_b_o;
  logic [31:0] alu_result_i;
  logic        alu_cmp_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic        res_cmp_o;
  logic [4:0]  res_rd_o;

  typedef struct packed {
    logic [31:0] data;
    logic        cmp;
    logic [4:0]  rd;
  } res_t;

  logic [31:0] mregs [32];
  res_t        exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          ready_lows = 0;
  bit          rand_bp = 1'b0;
  logic [31:0] last_data = 32'd0;
  logic        last_cmp = 1'b0;
  logic [4:0]  last_rd = 5'd0;

  always #5 clk = ~clk;

  miriscv_alu_issue dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_op_i        (req_op_i),
    .req_rs1_i       (req_rs1_i),
    .req_rs2_i       (req_rs2_i),
    .req_rd_i        (req_rd_i),
    .req_imm_i       (req_imm_i),
    .req_use_imm_i   (req_use_imm_i),
    .alu_operator_o  (alu_operator_o),
    .alu_operand_a_o (alu_operand_a_o),
    .alu_operand_b_o (alu_operand_b_o),
    .alu_result_i    (alu_result_i),
    .alu_cmp_i       (alu_cmp_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_data_o      (res_data_o),
    .res_cmp_o       (res_cmp_o),
    .res_rd_o        (res_rd_o)
  );

  // Behavioural stand-in for miriscv_alu.
  function automatic logic alu_cmp_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd9:    return $signed(a) < $signed(b);
      5'd10:   return a < b;
      5'd11:   return $signed(a) >= $signed(b);
      5'd12:   return a >= b;
      5'd13:   return a == b;
      5'd14:   return a != b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_res_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a ^ b;
      5'd4:    return a | b;
      5'd5:    return a & b;
      5'd6:    return a << b[4:0];
      5'd7:    return a >> b[4:0];
      5'd8:    return 32'($signed(a) >>> b[4:0]);
      5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: return {31'd0, alu_cmp_f(op, a, b)};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result_i = alu_res_f(alu_operator_o, alu_operand_a_o, alu_operand_b_o);
  assign alu_cmp_i    = alu_cmp_f(alu_operator_o, alu_operand_a_o, alu_operand_b_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic ui);
    bit acc;
    acc = 1'b0;
    req_valid_i = 1'b1; req_op_i = op; req_rs1_i = rs1; req_rs2_i = rs2;
    req_rd_i = rd; req_imm_i = imm; req_use_imm_i = ui;
    for (int w = 0; w < 64 && !acc; w++) begin
      if (rand_bp) res_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_ready_o;
      step();
      if (!acc) ready_lows++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Reference model: architectural register state updated at acceptance, results compared in order.
  initial begin
    res_t        e;
    logic [31:0] a;
    logic [31:0] b;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        exp_q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else begin
        if (res_valid_o && res_ready_i) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("res_data", res_data_o, e.data);
            check("res_cmp", 32'(res_cmp_o), 32'(e.cmp));
            check("res_rd", 32'(res_rd_o), 32'(e.rd));
          end
          last_data = res_data_o;
          last_cmp  = res_cmp_o;
          last_rd   = res_rd_o;
        end
        if (req_valid_i && req_ready_o) begin
          a = mregs[req_rs1_i];
          b = req_use_imm_i ? req_imm_i : mregs[req_rs2_i];
          e.data = alu_res_f(req_op_i, a, b);
          e.cmp  = alu_cmp_f(req_op_i, a, b);
          e.rd   = req_rd_i;
          exp_q.push_back(e);
          if (req_op_i >= 5'd1 && req_op_i <= 5'd8 && req_rd_i != 5'd0) mregs[req_rd_i] = e.data;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 5'd0; req_rs1_i = 5'd0; req_rs2_i = 5'd0;
    req_rd_i = 5'd0; req_imm_i = 32'd0; req_use_imm_i = 1'b0; res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_alu_op", 32'(alu_operator_o), 32'd0);
    check("rst_alu_a", alu_operand_a_o, 32'd0);
    check("rst_res_data", res_data_o, 32'd0);
    check("rst_res_rd", 32'(res_rd_o), 32'd0);

    // Latency: accepted in N, ALU driven in N+1, result visible in N+2.
    send(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
    check("t1_res_valid_n1", 32'(res_valid_o), 32'd0);
    check("t1_alu_op", 32'(alu_operator_o), 32'd1);
    check("t1_alu_a", alu_operand_a_o, 32'd0);
    check("t1_alu_b", alu_operand_b_o, 32'd5);
    step();
    check("t1_res_valid_n2", 32'(res_valid_o), 32'd1);
    check("t1_res_data", res_data_o, 32'd5);
    check("t1_res_rd", 32'(res_rd_o), 32'd1);
    drain();

    // Dependent pair: forwarded without a bubble, or exactly one bubble without forwarding.
    ready_lows = 0;
    send(OP_ADD, 5'd0, 5'd0, 5'd10, 32'd5, 1'b1);
    send(OP_ADD, 5'd10, 5'd0, 5'd11, 32'd7, 1'b1);
`ifdef MIRISCV_ISSUE_BYPASS_EN
    check("dep_ready_lows", 32'(ready_lows), 32'd0);
`else
    check("dep_ready_lows", 32'(ready_lows), 32'd1);
`endif
    drain();
    check("dep_data", last_data, 32'd12);
    check("dep_rd", 32'(last_rd), 32'd11);

    // Backpressure: third op stalls while the ALU drive holds the second op.
    res_ready_i = 1'b0;
    send(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
    send(OP_ADD, 5'd1, 5'd0, 5'd2, 32'd7, 1'b1);
    req_valid_i = 1'b1; req_op_i = OP_ADD; req_rs1_i = 5'd0; req_rd_i = 5'd12;
    req_imm_i = 32'd3; req_use_imm_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", 32'(req_ready_o), 32'd0);
      check("bp_alu_a", alu_operand_a_o, 32'd5);
      check("bp_alu_b", alu_operand_b_o, 32'd7);
      step();
    end
    res_ready_i = 1'b1;
    send(OP_ADD, 5'd0, 5'd0, 5'd12, 32'd3, 1'b1);
    drain();
    check("bp_last", last_data, 32'd3);

    // x0 stays zero.
    send(OP_ADD, 5'd0, 5'd0, 5'd0, 32'd9, 1'b1);
    send(OP_ADD, 5'd0, 5'd0, 5'd3, 32'd0, 1'b1);
    drain();
    check("x0_data", last_data, 32'd0);
    check("x0_rd", 32'(last_rd), 32'd3);

    // Signed compare, and compares never write their destination.
    send(OP_ADD, 5'd0, 5'd0, 5'd1, 32'(-321), 1'b1);
    send(OP_ADD, 5'd0, 5'd0, 5'd2, 32'd100, 1'b1);
    send(OP_LTS, 5'd1, 5'd2, 5'd4, 32'd0, 1'b0);
    drain();
    check("lts_cmp", 32'(last_cmp), 32'd1);
    check("lts_rd", 32'(last_rd), 32'd4);
    send(OP_ADD, 5'd4, 5'd0, 5'd5, 32'd0, 1'b1);
    drain();
    check("cmp_nowrite", last_data, 32'd0);

    // Reset with both slots full drops everything.
    res_ready_i = 1'b0;
    send(OP_ADD, 5'd0, 5'd0, 5'd7, 32'd1, 1'b1);
    send(OP_ADD, 5'd0, 5'd0, 5'd8, 32'd2, 1'b1);
    check("full_req_ready", 32'(req_ready_o), 32'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_rst_res_valid", 32'(res_valid_o), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    check("mid_rst_alu_op", 32'(alu_operator_o), 32'd0);
    res_ready_i = 1'b1;
    send(OP_ADD, 5'd1, 5'd0, 5'd6, 32'd0, 1'b1);
    drain();
    check("mid_rst_x1", last_data, 32'd0);
    check("mid_rst_rd", 32'(last_rd), 32'd6);

    // Randomized traffic with random backpressure and idle gaps.
    rand_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        res_ready_i = ($urandom_range(0, 1) != 0);
        step();
      end
      send(5'($urandom_range(0, 17)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    res_ready_i = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
